// File: rtl/alu_uart_master_if.sv
// Command/response handshake plus UART FIFO-pair signals for the ALU-over-UART
// initiator; master is the initiator's view, slave the environment's.
interface alu_uart_master_if #(
  parameter int DBIT  = 8,
  parameter int NB_OP = 6,
  parameter int NB_AB = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [NB_OP-1:0] op_code;
  logic [NB_AB-1:0] data_a;
  logic [NB_AB-1:0] data_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [NB_AB-1:0] result;
  logic             timeout_err;
  logic             tx_full;
  logic             wr_uart;
  logic [DBIT-1:0]  w_data;
  logic             rx_empty;
  logic             rd_uart;
  logic [DBIT-1:0]  r_data;

  modport master (
    input  cmd_valid, op_code, data_a, data_b, resp_ready,
    input  tx_full, rx_empty, r_data,
    output cmd_ready, resp_valid, result, timeout_err,
    output wr_uart, w_data, rd_uart
  );

  modport slave (
    output cmd_valid, op_code, data_a, data_b, resp_ready,
    output tx_full, rx_empty, r_data,
    input  cmd_ready, resp_valid, result, timeout_err,
    input  wr_uart, w_data, rd_uart
  );
endinterface

// File: rtl/alu_uart_master.sv
// Host-side ALU-over-UART initiator: pushes op, A, B into the TX FIFO, waits
// (bounded) for one result byte from the RX FIFO and returns it as a response.
module alu_uart_master #(
  parameter int DBIT           = 8,
  parameter int NB_OP          = 6,
  parameter int NB_AB          = 8,
  parameter int NB_TO          = 20,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  alu_uart_master_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_OP,
    SEND_A,
    SEND_B,
    WAIT_RES,
    DONE
  } state_t;

  localparam logic [NB_TO-1:0] TO_LAST = NB_TO'(TIMEOUT_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [NB_OP-1:0] op_reg, op_next;
  logic [NB_AB-1:0] a_reg, a_next;
  logic [NB_AB-1:0] b_reg, b_next;
  logic [NB_AB-1:0] result_reg, result_next;
  logic             timeout_err_reg, timeout_err_next;
  logic             resp_valid_reg, resp_valid_next;
  logic [NB_TO-1:0] cnt_reg, cnt_next;

  logic             cmd_ready;
  logic             wr_uart;
  logic             rd_uart;
  logic [DBIT-1:0]  w_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      op_reg          <= '0;
      a_reg           <= '0;
      b_reg           <= '0;
      result_reg      <= '0;
      timeout_err_reg <= 1'b0;
      resp_valid_reg  <= 1'b0;
      cnt_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      op_reg          <= op_next;
      a_reg           <= a_next;
      b_reg           <= b_next;
      result_reg      <= result_next;
      timeout_err_reg <= timeout_err_next;
      resp_valid_reg  <= resp_valid_next;
      cnt_reg         <= cnt_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    op_next          = op_reg;
    a_next           = a_reg;
    b_next           = b_reg;
    result_next      = result_reg;
    timeout_err_next = timeout_err_reg;
    cnt_next         = cnt_reg;
    cmd_ready        = 1'b0;
    wr_uart          = 1'b0;
    rd_uart          = 1'b0;
    w_data           = '0;

    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        // Anything left in RX here is stale (late reply or noise): drop it.
        rd_uart   = !bus.rx_empty;
        if (bus.cmd_valid) begin
          op_next    = bus.op_code;
          a_next     = bus.data_a;
          b_next     = bus.data_b;
          state_next = SEND_OP;
        end
      end
      SEND_OP: begin
        w_data  = DBIT'(op_reg);
        wr_uart = !bus.tx_full;
        if (!bus.tx_full) state_next = SEND_A;
      end
      SEND_A: begin
        w_data  = DBIT'(a_reg);
        wr_uart = !bus.tx_full;
        if (!bus.tx_full) state_next = SEND_B;
      end
      SEND_B: begin
        w_data  = DBIT'(b_reg);
        wr_uart = !bus.tx_full;
        if (!bus.tx_full) begin
          cnt_next   = '0;
          state_next = WAIT_RES;
        end
      end
      WAIT_RES: begin
        cnt_next = (cnt_reg == TO_LAST) ? cnt_reg : cnt_reg + NB_TO'(1);
        // A byte arriving on the final count still counts as a result.
        if (!bus.rx_empty) begin
          rd_uart          = 1'b1;
          result_next      = NB_AB'(bus.r_data);
          timeout_err_next = 1'b0;
          state_next       = DONE;
        end else if (cnt_reg == TO_LAST) begin
          result_next      = '0;
          timeout_err_next = 1'b1;
          state_next       = DONE;
        end
      end
      DONE: begin
        if (bus.resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    resp_valid_next = (state_next == DONE);
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.wr_uart     = wr_uart & ~reset;
  assign bus.rd_uart     = rd_uart & ~reset;
  assign bus.w_data      = w_data;
  assign bus.resp_valid  = resp_valid_reg;
  assign bus.result      = result_reg;
  assign bus.timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_alu_uart_master.sv
// Bench for alu_uart_master: TX/RX FIFOs modelled as queues, expectations taken
// from the transaction rules (byte order, timeout window, data-wins tie).
module tb_alu_uart_master;

  localparam int TO = 16;

  logic clk;
  logic reset;

  alu_uart_master_if #(.DBIT(8), .NB_OP(6), .NB_AB(8)) bus ();

  alu_uart_master #(
    .DBIT(8), .NB_OP(6), .NB_AB(8), .NB_TO(20), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int rd_count = 0;

  logic [7:0] rx_q[$];
  logic [7:0] push_q[$];

  logic       obs_wr, obs_rd, obs_rv, obs_cr, obs_to;
  logic [7:0] obs_wd, obs_res;

  // One clock cycle: present the RX head, sample outputs mid-cycle, apply the
  // FIFO side effects of the strobes, then advance past the rising edge.
  task automatic step();
    bus.rx_empty = (rx_q.size() == 0);
    bus.r_data   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    #1;
    obs_wr  = bus.wr_uart;
    obs_wd  = bus.w_data;
    obs_rd  = bus.rd_uart;
    obs_rv  = bus.resp_valid;
    obs_cr  = bus.cmd_ready;
    obs_res = bus.result;
    obs_to  = bus.timeout_err;
    if (bus.tx_full) begin
      total++;
      if (obs_wr !== 1'b0) begin
        bad++;
        $display("FAIL wr_while_full: wr_uart=%0b required 0", obs_wr);
      end
    end
    if (obs_wr === 1'b1) push_q.push_back(obs_wd);
    if (obs_rd === 1'b1) begin
      rd_count++;
      total++;
      if (rx_q.size() == 0) begin
        bad++;
        $display("FAIL rd_while_empty: rd_uart=1 required 0");
      end else begin
        void'(rx_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int stall_a, input int rx_delay, input int hold,
                         input logic [7:0] rx_byte);
    int n;
    int stalls;
    int w;
    int rd0;
    int k;
    logic       exp_data;
    int         exp_wait;
    logic [7:0] exp_res;
    logic       exp_to;

    exp_data = (rx_delay < TO);
    exp_wait = exp_data ? rx_delay + 1 : TO;
    exp_res  = exp_data ? rx_byte : 8'h00;
    exp_to   = !exp_data;

    push_q.delete();
    bus.op_code    = op;
    bus.data_a     = a;
    bus.data_b     = b;
    bus.tx_full    = 1'b0;
    bus.resp_ready = 1'b0;
    bus.cmd_valid  = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    total++;
    if (obs_cr !== 1'b1) begin
      bad++;
      $display("FAIL cmd_accept: cmd_ready=%0b required 1", obs_cr);
    end

    n = 0;
    stalls = 0;
    while (push_q.size() < 3 && n < 64) begin
      bus.tx_full = (push_q.size() == 1 && stalls < stall_a);
      if (bus.tx_full) stalls++;
      step();
      n++;
    end
    bus.tx_full = 1'b0;
    total++;
    if (n != 3 + stall_a) begin
      bad++;
      $display("FAIL push_cycles: took %0d cycles required %0d", n, 3 + stall_a);
    end
    total++;
    if (push_q.size() != 3 || push_q[0] !== {2'b00, op} || push_q[1] !== a || push_q[2] !== b) begin
      bad++;
      $display("FAIL tx_bytes: got %0d bytes %h %h %h required %h %h %h", push_q.size(),
               (push_q.size() > 0) ? push_q[0] : 8'hxx, (push_q.size() > 1) ? push_q[1] : 8'hxx,
               (push_q.size() > 2) ? push_q[2] : 8'hxx, {2'b00, op}, a, b);
    end

    rd0 = rd_count;
    w = 0;
    forever begin
      if (w == rx_delay) rx_q.push_back(rx_byte);
      step();
      if (obs_rv === 1'b1 || w > 64) break;
      w++;
    end
    total++;
    if (w != exp_wait) begin
      bad++;
      $display("FAIL wait_cycles: waited %0d cycles required %0d", w, exp_wait);
    end
    total++;
    if (obs_res !== exp_res || obs_to !== exp_to) begin
      bad++;
      $display("FAIL response: result=%h timeout_err=%0b required %h %0b", obs_res, obs_to, exp_res, exp_to);
    end

    for (int i = 0; i < hold; i++) begin
      step();
      total++;
      if (obs_rv !== 1'b1 || obs_res !== exp_res || obs_to !== exp_to || obs_cr !== 1'b0) begin
        bad++;
        $display("FAIL resp_hold: rv=%0b res=%h to=%0b cr=%0b required 1 %h %0b 0",
                 obs_rv, obs_res, obs_to, obs_cr, exp_res, exp_to);
      end
    end
    total++;
    if (rd_count - rd0 != (exp_data ? 1 : 0)) begin
      bad++;
      $display("FAIL rd_pulses: got %0d required %0d", rd_count - rd0, exp_data ? 1 : 0);
    end

    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    step();
    total++;
    if (obs_rv !== 1'b0 || obs_cr !== 1'b1) begin
      bad++;
      $display("FAIL resp_release: resp_valid=%0b cmd_ready=%0b required 0 1", obs_rv, obs_cr);
    end
    k = 0;
    while (rx_q.size() > 0 && k < 8) begin
      step();
      k++;
    end
    total++;
    if (push_q.size() != 3 || rx_q.size() != 0) begin
      bad++;
      $display("FAIL txn_tail: pushes=%0d rx_left=%0d required 3 0", push_q.size(), rx_q.size());
    end
    $display("txn op=%h a=%h b=%h stall=%0d delay=%0d -> result=%h timeout_err=%0b",
             op, a, b, stall_a, rx_delay, exp_res, exp_to);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++;
    if (obs_cr !== 1'b1 || obs_rv !== 1'b0 || obs_wr !== 1'b0 || obs_rd !== 1'b0 ||
        obs_wd !== 8'h00 || obs_res !== 8'h00 || obs_to !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: cr=%0b rv=%0b wr=%0b rd=%0b wd=%h res=%h to=%0b required 1 0 0 0 00 00 0",
               obs_cr, obs_rv, obs_wr, obs_rd, obs_wd, obs_res, obs_to);
    end
    reset = 1'b0;
    step();
    $display("txn reset");
  endtask

  task automatic test_basic();
    run_cmd(6'h20, 8'h05, 8'h03, 0, 0, 0, 8'h08);
  endtask

  task automatic test_tx_stall();
    run_cmd(6'h22, 8'hFF, 8'h01, 4, 2, 1, 8'h3C);
  endtask

  task automatic test_timeout();
    run_cmd(6'h11, 8'h42, 8'h24, 0, 1000, 2, 8'h00);
  endtask

  task automatic test_last_cycle_data();
    run_cmd(6'h07, 8'h10, 8'h20, 0, TO - 1, 0, 8'h5A);
  endtask

  task automatic test_stray_bytes();
    int rd0;
    rd0 = rd_count;
    rx_q.push_back(8'hA1);
    rx_q.push_back(8'hB2);
    step();
    step();
    step();
    total++;
    if (rd_count - rd0 != 2 || rx_q.size() != 0) begin
      bad++;
      $display("FAIL stray_discard: pops=%0d left=%0d required 2 0", rd_count - rd0, rx_q.size());
    end
    run_cmd(6'h3F, 8'h77, 8'h88, 0, 3, 10, 8'hC3);
  endtask

  task automatic test_reset_mid();
    push_q.delete();
    bus.op_code   = 6'h15;
    bus.data_a    = 8'hAA;
    bus.data_b    = 8'h55;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    bus.tx_full = 1'b1;
    step();
    bus.tx_full = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (bus.cmd_ready !== 1'b1 || bus.wr_uart !== 1'b0 || bus.rd_uart !== 1'b0 || bus.resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: cr=%0b wr=%0b rd=%0b rv=%0b required 1 0 0 0",
               bus.cmd_ready, bus.wr_uart, bus.rd_uart, bus.resp_valid);
    end
    step();
    reset = 1'b0;
    step();
    total++;
    if (push_q.size() != 2 || obs_wr !== 1'b0 || obs_cr !== 1'b1) begin
      bad++;
      $display("FAIL reset_abort: pushes=%0d wr=%0b cr=%0b required 2 0 1", push_q.size(), obs_wr, obs_cr);
    end
    $display("txn reset during SEND_B");
    run_cmd(6'h01, 8'h02, 8'h03, 0, 0, 0, 8'h05);
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        rx_q.push_back(8'($urandom));
        step();
        step();
      end
      run_cmd(6'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), 8'($urandom));
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.op_code    = '0;
    bus.data_a     = '0;
    bus.data_b     = '0;
    bus.resp_ready = 1'b0;
    bus.tx_full    = 1'b0;
    bus.rx_empty   = 1'b1;
    bus.r_data     = '0;
    test_reset();
    test_basic();
    test_tx_stall();
    test_timeout();
    test_last_cycle_data();
    test_stray_bytes();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_uart_master.md
Name: alu_uart_master

Overview:
- Host-side initiator for the ALU-over-UART link. Accepts one ALU command (op_code, data_a, data_b) through a valid/ready handshake.
- Serialises the command as three bytes into the UART TX FIFO, then waits for the single result byte in the UART RX FIFO.
- Returns the result, or a timeout error, through a valid/ready response handshake.
- Sits between a command source (test sequencer or soft core) and the uart_tx/uart_rx FIFO pair on the board that talks to the ALU side.

Parameters:
- DBIT, 8, UART data bits; byte width of w_data/r_data.
- NB_OP, 6, op_code width; must be <= DBIT.
- NB_AB, 8, operand and result width; must equal DBIT.
- NB_TO, 20, timeout counter width.
- TIMEOUT_CYCLES, 1000000, clk cycles to wait for the result byte; must be in 1..2^NB_TO-1.

Ports:
- clk  input  1  clock
- reset  input  1  reset (asynchronous, active-high)
- cmd_valid  input  1  command present
- cmd_ready  output  1  master can accept a command
- op_code  input  NB_OP  ALU operation
- data_a  input  NB_AB  operand A
- data_b  input  NB_AB  operand B
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- result  output  NB_AB  ALU result byte (0 on timeout)
- timeout_err  output  1  response is a timeout, not a result
- tx_full  input  1  TX FIFO full
- wr_uart  output  1  TX FIFO push strobe
- w_data  output  DBIT  TX FIFO write byte
- rx_empty  input  1  RX FIFO empty
- rd_uart  output  1  RX FIFO pop strobe
- r_data  input  DBIT  RX FIFO head byte (first-word-fall-through; valid while rx_empty=0)

Behaviour:
- Reset is asynchronous and active-high, on clock clk.
  - state=IDLE; op/a/b capture registers, result, timeout_err, and the timeout counter all cleared.
  - cmd_ready=1 (IDLE decode). resp_valid=0, wr_uart=0, rd_uart=0, w_data=0.
- Reset mid-transaction aborts immediately. No further FIFO strobes are issued. Bytes already pushed or unread are not recalled.
- States: IDLE, SEND_OP, SEND_A, SEND_B, WAIT_RES, DONE.
- Output timing:
  - wr_uart, rd_uart, w_data and cmd_ready are combinational decodes of the state and the FIFO flags.
  - result, timeout_err and resp_valid are registered.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: capture op_code, data_a, data_b and go to SEND_OP.
  - Stray RX bytes: if rx_empty=0, assert rd_uart=1 that cycle and discard r_data. This happens independently of cmd_valid.
- SEND_OP:
  - w_data = zero-extended op_code, i.e. {(DBIT-NB_OP) zeros, op}.
  - If tx_full=0: wr_uart=1 and go to SEND_A. Otherwise hold with wr_uart=0.
- SEND_A: w_data = captured A. Same tx_full rule; go to SEND_B.
- SEND_B:
  - w_data = captured B. Same tx_full rule; go to WAIT_RES.
  - Clear the timeout counter on the transition.
- Byte order on the wire is fixed: op, A, B. One push per cycle at most. Back-to-back pushes are allowed when tx_full stays 0.
- WAIT_RES: the counter increments each cycle.
  - If rx_empty=0: rd_uart=1, result<=r_data, timeout_err<=0, go to DONE.
  - Else, if counter==TIMEOUT_CYCLES-1: result<=0, timeout_err<=1, go to DONE.
  - If data arrives in the same cycle the timeout expires, data wins (timeout_err=0).
- DONE:
  - resp_valid=1; result and timeout_err are held stable.
  - On resp_ready=1: resp_valid falls the next cycle and the state returns to IDLE.
  - RX bytes arriving in DONE are left in the FIFO and flushed by the IDLE discard.
- Latency with FIFOs never full and the response present immediately:
  - cmd accept to first push: 1 cycle.
  - Three pushes in consecutive cycles.
  - Pop in the first WAIT_RES cycle.
  - resp_valid asserted the following cycle.
- Widths: NB_AB == DBIT, so there is no truncation on result. The counter saturates logically at TIMEOUT_CYCLES-1 and never wraps within a transaction.

Test Plan:
- Reset, then cmd op=0x20, A=0x05, B=0x03 with FIFOs idle, RX byte 0x08 presented after B is pushed -> wr_uart pulses three consecutive cycles with w_data 0x20, 0x05, 0x03; one rd_uart pulse; resp_valid=1 with result=0x08, timeout_err=0.
- tx_full held high for 4 cycles while in SEND_A (op=0x22, A=0xFF, B=0x01) -> no wr_uart during the stall; byte 0xFF is pushed exactly once when tx_full drops; order op, A, B preserved.
- TIMEOUT_CYCLES=16, no RX byte after the command -> exactly 16 WAIT_RES cycles; resp_valid=1 with timeout_err=1 and result=0x00; rd_uart never asserted.
- TIMEOUT_CYCLES=16, RX byte 0x5A becomes available on exactly the 16th WAIT_RES cycle -> result=0x5A, timeout_err=0, one rd_uart pulse.
- Two stray bytes in RX while IDLE, then a command -> two rd_uart discard pulses; the subsequent response reflects only the byte arriving after B; resp_ready held low for 10 cycles keeps resp_valid and result stable and cmd_ready=0.
- Assert reset during SEND_B -> next cycle state is IDLE with cmd_ready=1, no wr_uart or rd_uart, resp_valid=0; a following command completes normally.
